rx_frame_fifo: RTL and testbench
================================

# rx_frame_fifo

Store-and-forward frame buffer that sits directly downstream of the tri-mode Ethernet MAC receiver and consumes its user-side AXIS stream. A frame is made visible to the downstream consumer only after its last byte arrives with tuser low. Frames flagged bad (tuser high on tlast) and frames that overflow the buffer are discarded by rolling the write pointer back. The MAC side has no backpressure; the user side is a standard AXIS master with tready.

## Interface
Parameters:
- C_ADDR_WIDTH, 11: buffer depth is 2^C_ADDR_WIDTH bytes (default 2048).
- C_CNT_WIDTH, 16: width of the statistics counters.

Ports:
- rx_mac_aclk  in  1  single clock for all logic.
- rx_mac_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  byte from the MAC receiver.
- s_axis_tvalid  in  1  byte valid; there is no s_axis_tready.
- s_axis_tlast  in  1  last byte of frame; qualified by tvalid.
- s_axis_tuser  in  1  frame bad; sampled only when tvalid and tlast are both high.
- m_axis_tdata  out  8  buffered byte.
- m_axis_tvalid  out  1  output byte valid.
- m_axis_tready  in  1  consumer ready.
- m_axis_tlast  out  1  last byte of a good frame.
- rx_good_frames  out  C_CNT_WIDTH  number of frames committed.
- rx_drop_frames  out  C_CNT_WIDTH  number of frames discarded (bad or overflow).
- rx_overflow  out  1  one-cycle pulse when a frame is dropped for lack of space.

## Operation
- Storage: RAM of 2^C_ADDR_WIDTH entries × 9 bits ({tlast, tdata}).
- Pointers are C_ADDR_WIDTH+1 bits: wr_ptr, commit_ptr and rd_ptr. Addresses use the low C_ADDR_WIDTH bits and wrap modulo the depth.
- Full: wr_ptr − rd_ptr == 2^C_ADDR_WIDTH. Read-empty: rd_ptr == commit_ptr.
- Write FSM:
  - W_IDLE → W_WRITE on the first accepted beat.
  - W_WRITE → W_IDLE on tlast.
  - W_WRITE → W_DROP on an overflow without tlast.
  - W_DROP → W_IDLE on tlast.
- Every accepted beat in W_IDLE/W_WRITE is written at wr_ptr, then wr_ptr increments.
- A tlast beat in W_WRITE or W_IDLE:
  - tuser = 0 and not full: write the beat, commit_ptr ← wr_ptr+1, increment rx_good_frames.
  - tuser = 1: no write, wr_ptr ← commit_ptr, increment rx_drop_frames.
- Overflow is a beat arriving while full:
  - wr_ptr ← commit_ptr, pulse rx_overflow, increment rx_drop_frames once.
  - If that beat has tlast, go to W_IDLE. Otherwise go to W_DROP.
- W_DROP discards all beats, tuser ignored, until tlast, then goes to W_IDLE. No further counting.
- Read side:
  - Prefetch output register (FWFT). The RAM read is issued when the output register is empty, or is being emptied, and rd_ptr != commit_ptr.
  - A beat transfers when m_axis_tvalid && m_axis_tready. m_axis_tdata and m_axis_tlast hold stable while tvalid is high and tready is low.
- Counters saturate at all-ones (no wrap).
- Reset mid-frame: all pointers reset to 0, the FSM goes to W_IDLE, and any partial or uncommitted data is lost.
- After reset the block waits for a new tvalid. A frame already in progress upstream is stored from its next byte onward, so the consumer relies on the upstream tuser for that frame.

## Timing
- Reset values:
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - rx_overflow = 0, both counters = 0.
  - FSM = W_IDLE, all pointers = 0.
- commit_ptr updates on the clock edge that accepts the good tlast.
- Latency with the buffer read-empty and m_axis_tready = 1: m_axis_tvalid for the frame's first byte rises exactly 2 cycles after the commit edge. Cycle 1 is the RAM read; cycle 2 is the output register load.
- Sustained output: 1 byte per cycle while tready = 1 and committed data remains. Throughput across frame boundaries has no bubble.
- Simultaneous write and read: fullness is computed from rd_ptr before the read increment. A beat arriving full in the same cycle as a read is still an overflow (conservative).
- rx_overflow and counter increments are registered and visible 1 cycle after the triggering beat.

## Configuration
- RX_FIFO_STATS_EN:
  - Defined: rx_good_frames, rx_drop_frames and rx_overflow behave as specified.
  - Undefined: the counter logic is not compiled. Both counters and rx_overflow are tied to 0, and data-path behaviour is identical.

## Test plan
- One 64-byte good frame (bytes 0x00..0x3F, tuser = 0), tready = 1 → the output stream is 0x00..0x3F; tlast is high only on 0x3F; tvalid rises 2 cycles after input tlast; rx_good_frames = 1.
- A 60-byte frame with tuser = 1 on tlast, followed by a 46-byte good frame → only the 46-byte frame appears at the output; rx_drop_frames = 1; no bytes of the bad frame leak.
- C_ADDR_WIDTH = 6, tready = 0, a 40-byte good frame then a 40-byte frame → the second frame overflows; rx_overflow pulses once; drop = 1, good = 1. With tready then set to 1, exactly 40 bytes are output.
- A frame is committed while tready toggles 1/0 every cycle → data is held stable during stalls; 64 bytes are output in order with no duplicates.
- Reset asserted at byte 20 of a frame, released, then a 64-byte good frame is sent → all outputs are at reset values during reset; afterwards only the new frame is output and good = 1.
- Pointer wrap-around: with C_ADDR_WIDTH = 6, 10 back-to-back 50-byte good frames with tready = 1 → all 500 bytes are output in order with no loss.

Source files
------------

// File: rtl/rx_frame_fifo.sv
// Store-and-forward receive frame buffer between the MAC receiver and an AXIS consumer.
// Optional statistics (good/drop counters, overflow pulse) are built when RX_FIFO_STATS_EN is defined.
module rx_frame_fifo #(
  parameter int C_ADDR_WIDTH = 11,
  parameter int C_CNT_WIDTH  = 16
) (
  input  logic                   rx_mac_aclk,
  input  logic                   rx_mac_resetn,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [C_CNT_WIDTH-1:0] rx_good_frames,
  output logic [C_CNT_WIDTH-1:0] rx_drop_frames,
  output logic                   rx_overflow
);

  localparam int unsigned DEPTH = 2 ** C_ADDR_WIDTH;
  localparam logic [C_ADDR_WIDTH:0] FULL_DIFF = {1'b1, {C_ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wstate_t;

  logic [8:0]            mem [DEPTH];
  logic [C_ADDR_WIDTH:0] wr_ptr, commit_ptr, rd_ptr;
  wstate_t               state, state_nxt;
  logic                  full;
  logic                  do_write, do_commit, do_rollback, ovf_evt, bad_evt;

  // Fullness uses rd_ptr before any same-cycle read increment.
  assign full = (wr_ptr - rd_ptr) == FULL_DIFF;

  always_comb begin
    state_nxt   = state;
    do_write    = 1'b0;
    do_commit   = 1'b0;
    do_rollback = 1'b0;
    ovf_evt     = 1'b0;
    bad_evt     = 1'b0;
    case (state)
      W_IDLE, W_WRITE: begin
        if (s_axis_tvalid) begin
          if (full) begin
            ovf_evt     = 1'b1;
            do_rollback = 1'b1;
            state_nxt   = s_axis_tlast ? W_IDLE : W_DROP;
          end else if (s_axis_tlast && s_axis_tuser) begin
            bad_evt     = 1'b1;
            do_rollback = 1'b1;
            state_nxt   = W_IDLE;
          end else begin
            do_write  = 1'b1;
            do_commit = s_axis_tlast;
            state_nxt = s_axis_tlast ? W_IDLE : W_WRITE;
          end
        end
      end
      W_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_nxt = W_IDLE;
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
    if (!rx_mac_resetn) begin
      state      <= W_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (do_rollback)   wr_ptr <= commit_ptr;
      else if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_commit)     commit_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge rx_mac_aclk) begin
    if (do_write) mem[wr_ptr[C_ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  // Read pipeline: RAM output stage (pend/ram_q) feeding the FWFT output register.
  logic       pend, stage_adv, rd_issue;
  logic [8:0] ram_q;

  assign stage_adv = pend && (!m_axis_tvalid || m_axis_tready);
  assign rd_issue  = (rd_ptr != commit_ptr) && (!pend || stage_adv);

  always_ff @(posedge rx_mac_aclk) begin
    if (rd_issue) ram_q <= mem[rd_ptr[C_ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
    if (!rx_mac_resetn) begin
      rd_ptr        <= '0;
      pend          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      if (rd_issue)       pend <= 1'b1;
      else if (stage_adv) pend <= 1'b0;
      if (stage_adv) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= ram_q[7:0];
        m_axis_tlast  <= ram_q[8];
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef RX_FIFO_STATS_EN
  logic [C_CNT_WIDTH-1:0] good_cnt, drop_cnt;
  logic                   ovf_q;

  always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
    if (!rx_mac_resetn) begin
      good_cnt <= '0;
      drop_cnt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= ovf_evt;
      if (do_commit && good_cnt != '1)              good_cnt <= good_cnt + 1'b1;
      if ((ovf_evt || bad_evt) && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign rx_good_frames = good_cnt;
  assign rx_drop_frames = drop_cnt;
  assign rx_overflow    = ovf_q;
`else
  logic unused_stats;
  assign unused_stats   = ovf_evt ^ bad_evt;
  assign rx_good_frames = '0;
  assign rx_drop_frames = '0;
  assign rx_overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Directed scoreboard bench for rx_frame_fifo (C_ADDR_WIDTH = 6).
// Counter expectations follow RX_FIFO_STATS_EN: modelled values when defined, zero otherwise.
module tb_rx_frame_fifo;
  localparam int AW = 6;
`ifdef RX_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tuser;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic [15:0] good_frames, drop_frames;
  logic        overflow;

  rx_frame_fifo #(.C_ADDR_WIDTH(AW), .C_CNT_WIDTH(16)) dut (
    .rx_mac_aclk   (clk),
    .rx_mac_resetn (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .rx_good_frames(good_frames),
    .rx_drop_frames(drop_frames),
    .rx_overflow   (overflow)
  );

  always #5 clk = ~clk;

  int         cmps = 0;
  int         errs = 0;
  logic [8:0] sb[$];
  int         ready_mode = 0;   // 0: ready high, 1: ready low, 2: toggle each cycle
  int         exp_good = 0, exp_drop = 0, exp_ovf = 0, ovf_seen = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmps++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of input, check the output side, then advance to 1ns past the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic u);
    logic [8:0] e;
    s_tvalid = v; s_tdata = d; s_tlast = l; s_tuser = u;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'b0;
      default: m_tready = ~m_tready;
    endcase
    if (prev_stall) chk("hold_stable", 32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, prev_beat}));
    if (overflow === 1'b1) ovf_seen++;
    if (m_tvalid === 1'b1 && m_tready) begin
      chk("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_beat", 32'({m_tlast, m_tdata}), 32'(e));
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = {m_tlast, m_tdata};
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // kind 0: good frame (queued), 1: bad frame (tuser on tlast), 2: frame expected to overflow
  task automatic send_frame(input int len, input logic [7:0] base, input int kind);
    logic [8:0] fr[$];
    logic       last;
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      last = (i == len - 1);
      b    = 8'(int'(base) + i);
      step(1'b1, b, last, last && (kind == 1));
      if (kind == 0) fr.push_back({last, b});
    end
    foreach (fr[j]) sb.push_back(fr[j]);
  endtask

  task automatic drain(input int max_cycles);
    int k = 0;
    while ((sb.size() != 0 || m_tvalid === 1'b1) && k < max_cycles) begin
      idle(1);
      k++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    idle(4);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_good"}, 32'(good_frames), STATS ? 32'(exp_good) : 32'd0);
    chk({tag, "_drop"}, 32'(drop_frames), STATS ? 32'(exp_drop) : 32'd0);
    chk({tag, "_ovf"},  32'(ovf_seen),    STATS ? 32'(exp_ovf)  : 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_tlast"},  32'(m_tlast),  32'd0);
    chk({tag, "_tdata"},  32'(m_tdata),  32'd0);
    chk({tag, "_ovf"},    32'(overflow), 32'd0);
    chk({tag, "_good"},   32'(good_frames), 32'd0);
    chk({tag, "_drop"},   32'(drop_frames), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 64-byte good frame: first output beat exactly 2 cycles after the commit edge
    send_frame(64, 8'h00, 0);
    exp_good++;
    chk("latency_c0", 32'(m_tvalid), 32'd0);
    idle(1);
    chk("latency_c1", 32'(m_tvalid), 32'd0);
    idle(1);
    chk("latency_c2", 32'(m_tvalid), 32'd1);
    check_counts("frame64");
    drain(200);

    // bad frame followed by a good one; the bad bytes must not leak
    send_frame(60, 8'h80, 1);
    exp_drop++;
    send_frame(46, 8'h10, 0);
    exp_good++;
    drain(200);
    check_counts("bad_then_good");

    // overflow with the consumer stalled
    ready_mode = 1;
    send_frame(40, 8'h40, 0);
    exp_good++;
    send_frame(40, 8'hC0, 2);
    exp_drop++;
    exp_ovf++;
    idle(3);
    check_counts("overflow");
    ready_mode = 0;
    drain(200);

    // tready toggling every cycle
    ready_mode = 2;
    send_frame(64, 8'h55, 0);
    exp_good++;
    drain(400);
    ready_mode = 0;
    idle(1);
    check_counts("toggle");

    // reset in the middle of a frame
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    exp_good = 0; exp_drop = 0; exp_ovf = 0; ovf_seen = 0;
    prev_stall = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(64, 8'h20, 0);
    exp_good++;
    drain(200);
    check_counts("after_reset");

    // pointer wrap: ten back-to-back 50-byte frames
    for (int f = 0; f < 10; f++) begin
      send_frame(50, 8'(f * 50), 0);
      exp_good++;
    end
    drain(1000);
    check_counts("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
